servo_pulse_decoder: RTL
========================

Name: servo_pulse_decoder

Overview:
- Receive side of the servo PWM link: samples an incoming 50 Hz servo pulse train (700–2300 us high time in a 20 ms frame) on clk_100M.
- Measures the high time in 10 us ticks, validates width and frame period, and converts the width back to an angle of 0–180.
- Used for loopback checking of the servo output path and for reading RC receiver channels.

Parameters:
- TICK_DIV, 1000, clk_100M cycles per measurement tick (10 us).
- MIN_PW, 70, ticks mapping to angle 0.
- MAX_PW, 230, ticks mapping to angle 180.
- PW_TOL, 10, ticks of tolerance accepted outside MIN_PW..MAX_PW (clamped).
- PERIOD_MIN, 1800, minimum accepted frame period in ticks.
- PERIOD_MAX, 2200, maximum accepted frame period in ticks.
- TIMEOUT, 2500, ticks without a rising edge before the link is declared lost.

Ports:
- clk_100M  in  1  100 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  decoder enable.
- pulse_in  in  1  asynchronous servo pulse input.
- angle  out  8  decoded angle, 0–180.
- pulsewidth  out  12  last accepted high time in ticks.
- valid  out  1  high while a good frame has been accepted and no timeout has occurred since.
- angle_stb  out  1  one-cycle strobe on each accepted frame.
- bad_pulse  out  1  one-cycle strobe on each rejected frame.
- timeout  out  1  level; set on signal loss, cleared by the next accepted frame.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM in IDLE, all counters 0.
- Input conditioning:
  - 2-flop synchronizer on pulse_in, then a registered edge detector.
  - Rising/falling edge pulses appear 3 clk_100M cycles after an input transition.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1; tick is asserted for one cycle when the counter equals TICK_DIV-1.
  - The counter is cleared on every rising edge so that measurement phase is aligned to the frame.
- Width and period counters:
  - 12-bit hi_cnt and per_cnt increment on tick; both saturate at 4095 and never wrap.
- FSM:
  - IDLE: counters held at 0. On a rising edge -> HIGH, with hi_cnt=0 and per_cnt=0.
  - HIGH: hi_cnt and per_cnt count. On a falling edge, latch hi_cnt into hi_lat -> LOW.
  - LOW: per_cnt counts.
    - On a rising edge: evaluate the frame (see Frame acceptance), clear the counters, stay in the measure loop -> HIGH.
    - If per_cnt reaches TIMEOUT: set timeout, clear valid -> IDLE.
  - The TIMEOUT check also applies in HIGH (stuck-high input) -> IDLE with timeout set; no bad_pulse strobe in this case.
- Frame acceptance, on the rising edge that closes the frame:
  - Good when hi_lat lies in MIN_PW-PW_TOL..MAX_PW+PW_TOL AND per_cnt lies in PERIOD_MIN..PERIOD_MAX.
  - Good frame, on the next cycle:
    - pulsewidth <= hi_lat;
    - angle <= conversion (below);
    - valid <= 1, timeout <= 0, angle_stb pulses for 1 cycle.
  - Bad frame, on the next cycle: bad_pulse pulses for 1 cycle; angle, pulsewidth and valid hold.
  - The first rising edge after IDLE only starts measurement and is not evaluated.
- Angle conversion:
  - w = hi_lat clamped to MIN_PW..MAX_PW.
  - angle = ((w - MIN_PW) * 9) >> 3.
  - Intermediate width is 12 bits; the result fits 8 bits with a maximum of 180.
  - This conversion is the inverse of the transmit mapping pw = angle*8/9 + MIN_PW.
  - Truncation error of up to 2 degrees is expected and not an error.
- en low:
  - FSM forced to IDLE, counters cleared, valid and timeout cleared.
  - angle and pulsewidth hold; no strobes are generated.
  - Measurement restarts at the first rising edge after en returns high.
- Simultaneous events: a rising edge in the same cycle that per_cnt reaches TIMEOUT is treated as timeout (timeout wins).
- Reset mid-pulse: returns immediately to the reset state; the partial frame is discarded.

Test Plan:
- Each case below drives a 20.00 ms period input unless noted.
- 1500 us high time: after the 2nd rising edge -> pulsewidth=150, angle=90, valid=1, one angle_stb per frame thereafter.
- 700 us high time, then 2300 us high time -> angle=0, then angle=180; exactly one angle_stb per frame.
- 2400 us high time (240 ticks, within tolerance) -> pulsewidth=240, angle=180 (clamped). Then 3000 us high time -> bad_pulse strobe, angle stays 180, valid stays 1.
- 1500 us high time in a 15 ms frame -> bad_pulse each frame, valid never set from reset.
- Lock at 1500 us, then hold the input low -> timeout=1 and valid=0 25 ms (±10 us) after the last rising edge.
  - Restart pulses -> timeout clears and valid=1 after 2 good rising edges.
- Assert rst_n low midway through a 1500 us pulse -> all outputs 0 immediately.
  - After release, no angle_stb until a complete frame has been measured.
- Drop en for 5 ms while locked -> valid=0 and angle holds at 90; relock occurs on the 2nd rising edge after en goes high.

Source files
------------

// File: rtl/servo_pulse_decoder.sv
// Servo PWM receiver: measures high time and frame period of a servo pulse train
// in measurement ticks, validates the frame, and converts the accepted width to 0-180 degrees.
module servo_pulse_decoder #(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned MIN_PW     = 70,
    parameter int unsigned MAX_PW     = 230,
    parameter int unsigned PW_TOL     = 10,
    parameter int unsigned PERIOD_MIN = 1800,
    parameter int unsigned PERIOD_MAX = 2200,
    parameter int unsigned TIMEOUT    = 2500
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pulse_in,
    output logic [7:0]  angle,
    output logic [11:0] pulsewidth,
    output logic        valid,
    output logic        angle_stb,
    output logic        bad_pulse,
    output logic        timeout
);
    localparam int unsigned CNT_W = 12;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] PW_MIN_C = CNT_W'(MIN_PW);
    localparam logic [CNT_W-1:0] PW_MAX_C = CNT_W'(MAX_PW);
    localparam logic [CNT_W-1:0] PW_LO    = CNT_W'(MIN_PW - PW_TOL);
    localparam logic [CNT_W-1:0] PW_HI    = CNT_W'(MAX_PW + PW_TOL);
    localparam logic [CNT_W-1:0] PER_LO   = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0] PER_HI   = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t            state;
    logic              sync_q1, sync_q2, sync_d;
    logic              rise, fall;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [CNT_W-1:0]  hi_cnt, per_cnt, hi_lat;
    logic [CNT_W-1:0]  hi_next, per_next, w_clamp, ang_prod;
    logic              frame_good, period_expired;

    // Two-flop synchronizer followed by a registered edge detector
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_d  <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q1 <= pulse_in;
            sync_q2 <= sync_q1;
            sync_d  <= sync_q2;
            rise    <= sync_q2 & ~sync_d;
            fall    <= ~sync_q2 & sync_d;
        end
    end

    // Tick phase is realigned on every rising edge so the width count starts with the frame
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!en || rise || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Counter look-ahead, frame qualification and width-to-angle conversion
    always_comb begin
        hi_next  = hi_cnt;
        per_next = per_cnt;
        if (tick && (hi_cnt != CNT_SAT)) begin
            hi_next = hi_cnt + CNT_W'(1);
        end
        if (tick && (per_cnt != CNT_SAT)) begin
            per_next = per_cnt + CNT_W'(1);
        end

        w_clamp = hi_lat;
        if (hi_lat < PW_MIN_C) begin
            w_clamp = PW_MIN_C;
        end else if (hi_lat > PW_MAX_C) begin
            w_clamp = PW_MAX_C;
        end
        ang_prod = (w_clamp - PW_MIN_C) * CNT_W'(9);

        frame_good     = (hi_lat >= PW_LO) && (hi_lat <= PW_HI) &&
                         (per_next >= PER_LO) && (per_next <= PER_HI);
        period_expired = (per_next >= TO_LIM);
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hi_cnt     <= '0;
            per_cnt    <= '0;
            hi_lat     <= '0;
            angle      <= '0;
            pulsewidth <= '0;
            valid      <= 1'b0;
            angle_stb  <= 1'b0;
            bad_pulse  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            angle_stb <= 1'b0;
            bad_pulse <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                hi_cnt  <= '0;
                per_cnt <= '0;
                valid   <= 1'b0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        hi_cnt  <= '0;
                        per_cnt <= '0;
                        if (rise) begin
                            state <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (period_expired) begin
                            state   <= IDLE;
                            hi_cnt  <= '0;
                            per_cnt <= '0;
                            valid   <= 1'b0;
                            timeout <= 1'b1;
                        end else begin
                            hi_cnt  <= hi_next;
                            per_cnt <= per_next;
                            if (fall) begin
                                hi_lat <= hi_next;
                                state  <= LOW;
                            end
                        end
                    end
                    LOW: begin
                        // Timeout takes priority over a coincident closing edge
                        if (period_expired) begin
                            state   <= IDLE;
                            hi_cnt  <= '0;
                            per_cnt <= '0;
                            valid   <= 1'b0;
                            timeout <= 1'b1;
                        end else if (rise) begin
                            state   <= HIGH;
                            hi_cnt  <= '0;
                            per_cnt <= '0;
                            if (frame_good) begin
                                pulsewidth <= hi_lat;
                                angle      <= 8'(ang_prod >> 3);
                                valid      <= 1'b1;
                                timeout    <= 1'b0;
                                angle_stb  <= 1'b1;
                            end else begin
                                bad_pulse <= 1'b1;
                            end
                        end else begin
                            per_cnt <= per_next;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
